// File: rtl/shift_add_mul4.sv
// Sequential 4x4 unsigned shift-and-add multiplier driving an external 4-bit adder.
// Optional MUL_EARLY_TERM_EN: stop after the highest set multiplier bit.
module shift_add_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] mcand,
    input  logic [3:0] mplier,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_cin,
    input  logic [3:0] add_sum,
    input  logic       add_cout
);

    localparam int unsigned W  = 4;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mc_q, mc_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   product_q, product_d;
    logic [CW-1:0]   last_iter;
    logic [PW-1:0]   shifted;

`ifdef MUL_EARLY_TERM_EN
    logic [CW-1:0]   last_q, last_d;

    // Index of the final iteration: highest set multiplier bit, minimum 0.
    function automatic logic [CW-1:0] calc_last(input logic [W-1:0] m);
        if (m[3])      calc_last = CW'(3);
        else if (m[2]) calc_last = CW'(2);
        else if (m[1]) calc_last = CW'(1);
        else           calc_last = CW'(0);
    endfunction

    assign last_iter = last_q;
`else
    assign last_iter = CW'(W - 1);
`endif

    // {cout, sum, q} shifted right by one, dropping the consumed multiplier bit
    assign shifted = {add_cout, add_sum, q_q[W-1:1]};

    assign add_a   = (state_q == S_RUN) ? acc_q : '0;
    assign add_b   = (state_q == S_RUN && q_q[0]) ? mc_q : '0;
    assign add_cin = 1'b0;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mc_q      <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
`ifdef MUL_EARLY_TERM_EN
            last_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
`ifdef MUL_EARLY_TERM_EN
            last_q    <= last_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
`ifdef MUL_EARLY_TERM_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mc_d    = mcand;
                    q_d     = mplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef MUL_EARLY_TERM_EN
                    last_d  = calc_last(mplier);
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = shifted[PW-1:W];
                q_d   = shifted[W-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == last_iter) begin
                    // Early exit leaves the product un-normalised by the skipped shifts
`ifdef MUL_EARLY_TERM_EN
                    product_d = shifted >> (CW'(W - 1) - last_q);
`else
                    product_d = shifted;
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_add_mul4.sv
// Directed bench for shift_add_mul4 with a behavioural 4-bit adder attached.
module tb_shift_add_mul4;

`ifdef MUL_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] mcand, mplier;
    logic       busy, done;
    logic [7:0] product;
    logic [3:0] add_a, add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Downstream ripple-carry adder model
    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    shift_add_mul4 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mcand    (mcand),
        .mplier   (mplier),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    typedef struct {
        logic [3:0] mc;
        logic [3:0] mp;
        logic [7:0] prod;
        int         lat_full;
        int         lat_et;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a request for one edge; returns at the negedge after acceptance
    task automatic start_op(input logic [3:0] mc, input logic [3:0] mp, input string name);
        mcand  = mc;
        mplier = mp;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({name, " busy after start"}, int'(busy), 1);
        check({name, " done after start"}, int'(done), 0);
    endtask

    task automatic wait_done(input int exp_lat, input logic [7:0] exp_prod, input string name);
        int  cyc  = 0;
        bit  seen = 1'b0;
        while (!seen && cyc < 12) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
            else check({name, " busy while running"}, int'(busy), 1);
        end
        check({name, " latency"}, cyc, exp_lat);
        check({name, " product"}, int'(product), int'(exp_prod));
        check({name, " busy at done"}, int'(busy), 0);
    endtask

    task automatic check_held(input logic [7:0] exp_prod, input string name);
        tick();
        check({name, " done single pulse"}, int'(done), 0);
        check({name, " product held"}, int'(product), int'(exp_prod));
        check({name, " add_a idle"}, int'(add_a), 0);
        check({name, " add_b idle"}, int'(add_b), 0);
    endtask

    initial begin
        vecs[0] = '{4'd15, 4'd15, 8'hE1, 4, 4};
        vecs[1] = '{4'd9,  4'd0,  8'h00, 4, 1};
        vecs[2] = '{4'd7,  4'd3,  8'h15, 4, 2};
        vecs[3] = '{4'd13, 4'd11, 8'h8F, 4, 4};
        vecs[4] = '{4'd1,  4'd1,  8'h01, 4, 1};
        vecs[5] = '{4'd6,  4'd4,  8'h18, 4, 3};
        vecs[6] = '{4'd15, 4'd8,  8'h78, 4, 4};
        vecs[7] = '{4'd0,  4'd15, 8'h00, 4, 4};

        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        tick();
        tick();
        check("reset busy",    int'(busy),    0);
        check("reset done",    int'(done),    0);
        check("reset product", int'(product), 0);
        check("reset add_a",   int'(add_a),   0);
        check("reset add_b",   int'(add_b),   0);
        check("reset add_cin", int'(add_cin), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            start_op(vecs[i].mc, vecs[i].mp, nm);
            wait_done(ET ? vecs[i].lat_et : vecs[i].lat_full, vecs[i].prod, nm);
            check_held(vecs[i].prod, nm);
        end

        // Start and operand changes during RUN are ignored
        start_op(4'd5, 4'd6, "ignore");
        mcand = 4'd15; mplier = 4'd15; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("ignore still busy", int'(busy), 1);
        begin
            int c = 2;
            bit seen = 1'b0;
            while (!seen && c < 12) begin
                tick();
                c++;
                if (done) seen = 1'b1;
            end
            check("ignore latency", c, ET ? 3 : 4);
            check("ignore product", int'(product), 8'h1E);
        end
        check_held(8'h1E, "ignore");

        // Back-to-back: second start presented in the DONE cycle
        start_op(4'd3, 4'd4, "b2b first");
        wait_done(ET ? 3 : 4, 8'h0C, "b2b first");
        start_op(4'd2, 4'd2, "b2b second");
        wait_done(ET ? 2 : 4, 8'h04, "b2b second");
        check_held(8'h04, "b2b second");

        // Reset mid-run aborts with no done pulse
        start_op(4'd13, 4'd11, "abort");
        rst = 1'b1;
        tick();
        check("abort busy",    int'(busy),    0);
        check("abort done",    int'(done),    0);
        check("abort product", int'(product), 0);
        check("abort add_a",   int'(add_a),   0);
        check("abort add_b",   int'(add_b),   0);
        rst = 1'b0;
        begin
            int pulses = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (done) pulses++;
            end
            check("abort no done pulse", pulses, 0);
        end
        start_op(4'd13, 4'd11, "after abort");
        wait_done(4, 8'h8F, "after abort");
        check_held(8'h8F, "after abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
